// File: rtl/x7seg_pkg.sv
// Shared constants and display-state type for the x7seg_scan display controller.
package x7seg_pkg;

  localparam int unsigned MAX_DIG = 16;
  localparam int unsigned IDX_W   = 4;
  localparam logic [6:0]  SEG_OFF = 7'h7F;

  // Sized for the largest supported digit count; narrower builds zero-extend.
  typedef struct packed {
    logic [4*MAX_DIG-1:0] nib;
    logic [MAX_DIG-1:0]   dp;
    logic [MAX_DIG-1:0]   blank;
  } disp_t;

endpackage

// File: rtl/x7seg_scan_if.sv
// Register-file side and display-pin side signals of x7seg_scan.
interface x7seg_scan_if #(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned BRIGHT_W = 3
) ();
  logic [4*NDIG-1:0]   data;
  logic                load;
  logic [NDIG-1:0]     dp_in;
  logic [NDIG-1:0]     blank;
  logic                lz_en;
  logic [BRIGHT_W-1:0] bright;
  logic [NDIG-1:0]     blink_mask;
  logic [6:0]          a2g;
  logic [NDIG-1:0]     an;
  logic                dp;
  logic                frame;

  modport master (
    output data, load, dp_in, blank, lz_en, bright, blink_mask,
    input  a2g, an, dp, frame
  );

  modport slave (
    input  data, load, dp_in, blank, lz_en, bright, blink_mask,
    output a2g, an, dp, frame
  );
endinterface

// File: rtl/x7seg_scan_hex7seg.sv
// Hex7Seg: hex nibble to active-low segments, a2g[6]=a ... a2g[0]=g.
module Hex7Seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h7F;
    case (i_nib)
      4'h0: o_seg = ~7'h7E;
      4'h1: o_seg = ~7'h30;
      4'h2: o_seg = ~7'h6D;
      4'h3: o_seg = ~7'h79;
      4'h4: o_seg = ~7'h33;
      4'h5: o_seg = ~7'h5B;
      4'h6: o_seg = ~7'h5F;
      4'h7: o_seg = ~7'h70;
      4'h8: o_seg = ~7'h7F;
      4'h9: o_seg = ~7'h7B;
      4'hA: o_seg = ~7'h77;
      4'hB: o_seg = ~7'h1F;
      4'hC: o_seg = ~7'h4E;
      4'hD: o_seg = ~7'h3D;
      4'hE: o_seg = ~7'h4F;
      4'hF: o_seg = ~7'h47;
      default: o_seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/x7seg_scan.sv
// Multiplexed seven-segment controller: tear-free shadow/display buffers, blanking,
// leading-zero suppression and PWM brightness. Optional blink: X7SEG_BLINK_EN.
module x7seg_scan
  import x7seg_pkg::*;
#(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned DIV_W    = 17,
  parameter int unsigned BRIGHT_W = 3,
  parameter int unsigned BLINK_W  = 5
) (
  input  logic          clk,
  input  logic          clr_n,
  x7seg_scan_if.slave   bus
);

  logic [DIV_W-1:0] r_pre;
  logic [IDX_W-1:0] r_idx;
  disp_t            r_shadow;
  disp_t            r_disp;
  logic             r_pend;
  logic [6:0]       r_seg;
  logic [NDIG-1:0]  r_an;
  logic             r_dp;
  logic             r_frame;

  disp_t            w_in;
  logic             w_wrap;
  logic             w_bound;
  logic [IDX_W-1:0] w_hi;
  logic             w_supp;
  logic             w_duty;
  logic             w_blink_off;
  logic             w_en;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;

  always_comb begin
    w_in       = '0;
    w_in.nib   = (4*MAX_DIG)'(bus.data);
    w_in.dp    = MAX_DIG'(bus.dp_in);
    w_in.blank = MAX_DIG'(bus.blank);
  end

  assign w_wrap  = &r_pre;
  assign w_bound = w_wrap && (r_idx == IDX_W'(NDIG-1));

  // Highest nonzero nibble; digit 0 stays lit even when everything is zero.
  always_comb begin
    w_hi = '0;
    for (int unsigned i = 0; i < MAX_DIG; i++) begin
      if (r_disp.nib[4*i +: 4] != 4'h0) w_hi = IDX_W'(i);
    end
  end

  assign w_supp = bus.lz_en && (r_idx > w_hi);
  assign w_duty = (r_pre[DIV_W-1 -: BRIGHT_W] <= bus.bright);
  assign w_nib  = r_disp.nib[4*r_idx +: 4];

`ifdef X7SEG_BLINK_EN
  logic [BLINK_W-1:0] r_blink;
  logic [MAX_DIG-1:0] w_bmask;

  assign w_bmask     = MAX_DIG'(bus.blink_mask);
  assign w_blink_off = r_blink[BLINK_W-1] & w_bmask[r_idx];

  always_ff @(posedge clk) begin
    if (!clr_n)       r_blink <= '0;
    else if (w_bound) r_blink <= r_blink + 1'b1;
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^bus.blink_mask;
  assign w_blink_off    = 1'b0;
`endif

  assign w_en = !r_disp.blank[r_idx] && !w_supp && w_duty && !w_blink_off;

  Hex7Seg u_hex (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_disp   <= '0;
      r_pend   <= 1'b0;
      r_seg    <= SEG_OFF;
      r_an     <= '1;
      r_dp     <= 1'b1;
      r_frame  <= 1'b0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (w_wrap) r_idx <= w_bound ? '0 : r_idx + 1'b1;

      if (bus.load) begin
        r_shadow <= w_in;
        r_pend   <= 1'b1;
      end
      // A load on the boundary bypasses the shadow so it shows in the next frame.
      if (w_bound) begin
        if (bus.load) begin
          r_disp <= w_in;
          r_pend <= 1'b0;
        end else if (r_pend) begin
          r_disp <= r_shadow;
          r_pend <= 1'b0;
        end
      end

      r_frame <= w_bound;
      r_an    <= w_en ? ~(NDIG'(1) << r_idx) : '1;
      r_seg   <= w_en ? w_seg : SEG_OFF;
      r_dp    <= w_en ? ~r_disp.dp[r_idx] : 1'b1;
    end
  end

  assign bus.a2g   = r_seg;
  assign bus.an    = r_an;
  assign bus.dp    = r_dp;
  assign bus.frame = r_frame;

endmodule
